// File: rtl/vga_pkg.sv
// Shared VGA framebuffer constants and the write-arbiter state encoding.
package vga_pkg;
   localparam int VGA_ADDR_W   = 14;
   localparam int VGA_DATA_W   = 8;
   localparam int VGA_FB_WORDS = 16384;

   typedef enum logic {
      ST_ARB   = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_e;
endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant from two valids, holds the last-winner pointer.
module rr_arb2 (
   input  logic       clk48,
   input  logic       rst_n,
   input  logic [1:0] i_valid,
   input  logic       i_en,
   output logic [1:0] o_grant
);
   // r_last = index of the most recent winner; reset to 1 so requester 0 wins the first tie
   logic r_last;
   logic [1:0] w_grant;

   always_comb begin
      w_grant = 2'b00;
      if (i_en) begin
         if (i_valid == 2'b11) w_grant = r_last ? 2'b01 : 2'b10;
         else                  w_grant = i_valid;
      end
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n)         r_last <= 1'b1;
      else if (|w_grant)  r_last <= w_grant[1];
   end

   assign o_grant = w_grant;
endmodule

// File: rtl/vga_write_arbiter.sv
// Arbitrates two requesters onto the vgadisplay write port with a registered strobe.
// Optional screen-clear sequencer compiled in with `define VGA_ARB_CLEAR_EN.
module vga_write_arbiter
   import vga_pkg::*;
#(
   parameter int                ADDR_W     = VGA_ADDR_W,
   parameter int                DATA_W     = VGA_DATA_W,
   parameter int                CLEAR_LEN  = VGA_FB_WORDS,
   parameter logic [DATA_W-1:0] CLEAR_DATA = '0
) (
   input  logic              clk48,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_data,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_data,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic              clear_start,
   output logic              clear_busy,
   output logic [ADDR_W-1:0] vga_waddr,
   output logic [DATA_W-1:0] vga_wdata,
   output logic              vga_wr_en
);
   arb_state_e        r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_waddr, w_waddr_nxt;
   logic [DATA_W-1:0] r_wdata, w_wdata_nxt;
   logic              r_wr_en, w_wr_en_nxt;
   logic [1:0]        w_grant;
   logic              w_block;

`ifdef VGA_ARB_CLEAR_EN
   // Counter is one bit wider than the address so a full-framebuffer clear ends cleanly
   localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W+1)'(CLEAR_LEN - 1);
   logic [ADDR_W:0] r_cnt, w_cnt_nxt;

   assign w_block    = (r_state == ST_CLEAR) || clear_start;
   assign clear_busy = (r_state == ST_CLEAR);
`else
   logic w_unused_clear;

   assign w_unused_clear = clear_start;
   assign w_block        = 1'b0;
   assign clear_busy     = 1'b0;
`endif

   // rst_n gates the grant so ready drops the instant reset asserts
   rr_arb2 u_rr_arb2 (
      .clk48   (clk48),
      .rst_n   (rst_n),
      .i_valid ({req1_valid, req0_valid}),
      .i_en    (rst_n & ~w_block),
      .o_grant (w_grant)
   );

   assign req0_ready = w_grant[0];
   assign req1_ready = w_grant[1];

   always_comb begin
      w_state_nxt = r_state;
      w_waddr_nxt = r_waddr;
      w_wdata_nxt = r_wdata;
      w_wr_en_nxt = 1'b0;
`ifdef VGA_ARB_CLEAR_EN
      w_cnt_nxt   = r_cnt;
`endif
      unique case (r_state)
         ST_ARB: begin
            if (w_grant[0]) begin
               w_waddr_nxt = req0_addr;
               w_wdata_nxt = req0_data;
               w_wr_en_nxt = 1'b1;
            end else if (w_grant[1]) begin
               w_waddr_nxt = req1_addr;
               w_wdata_nxt = req1_data;
               w_wr_en_nxt = 1'b1;
            end
`ifdef VGA_ARB_CLEAR_EN
            if (clear_start) begin
               w_state_nxt = ST_CLEAR;
               w_cnt_nxt   = '0;
            end
`endif
         end
`ifdef VGA_ARB_CLEAR_EN
         ST_CLEAR: begin
            w_waddr_nxt = r_cnt[ADDR_W-1:0];
            w_wdata_nxt = CLEAR_DATA;
            w_wr_en_nxt = 1'b1;
            w_cnt_nxt   = r_cnt + 1'b1;
            if (r_cnt == LAST_WORD) w_state_nxt = ST_ARB;
         end
`endif
         default: w_state_nxt = ST_ARB;
      endcase
   end

   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_ARB;
         r_waddr <= '0;
         r_wdata <= '0;
         r_wr_en <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_waddr <= w_waddr_nxt;
         r_wdata <= w_wdata_nxt;
         r_wr_en <= w_wr_en_nxt;
      end
   end

`ifdef VGA_ARB_CLEAR_EN
   always_ff @(posedge clk48 or negedge rst_n) begin
      if (!rst_n) r_cnt <= '0;
      else        r_cnt <= w_cnt_nxt;
   end
`endif

   assign vga_waddr = r_waddr;
   assign vga_wdata = r_wdata;
   assign vga_wr_en = r_wr_en;
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Bench for vga_write_arbiter: vector table, scoreboard of expected writes, clear/reset sequences.
module tb_vga_write_arbiter;
   logic        clk48 = 1'b0;
   logic        rst_n;
   logic [13:0] req0_addr, req1_addr;
   logic [7:0]  req0_data, req1_data;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic        clear_start, clear_busy;
   logic [13:0] vga_waddr;
   logic [7:0]  vga_wdata;
   logic        vga_wr_en;

   typedef struct packed {
      logic [13:0] a;
      logic [7:0]  d;
   } wr_t;

   typedef struct packed {
      logic        v0;
      logic [13:0] a0;
      logic [7:0]  d0;
      logic        v1;
      logic [13:0] a1;
      logic [7:0]  d1;
      logic        er0;
      logic        er1;
   } vec_t;

   localparam int NV = 11;
   vec_t tbl [NV];
   wr_t  q [$];
   int   n_cmp = 0;
   int   n_bad = 0;

   vga_write_arbiter #(
      .ADDR_W(14), .DATA_W(8), .CLEAR_LEN(16), .CLEAR_DATA(8'h00)
   ) dut (
      .clk48(clk48), .rst_n(rst_n),
      .req0_addr(req0_addr), .req0_data(req0_data), .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req1_addr(req1_addr), .req1_data(req1_data), .req1_valid(req1_valid), .req1_ready(req1_ready),
      .clear_start(clear_start), .clear_busy(clear_busy),
      .vga_waddr(vga_waddr), .vga_wdata(vga_wdata), .vga_wr_en(vga_wr_en)
   );

   always #5 clk48 = ~clk48;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Every observed write strobe must match the oldest expected write
   always begin
      @(posedge clk48);
      #1;
      if (vga_wr_en === 1'b1) begin
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_unexpected: got write addr 0x%0h data 0x%0h expected none", vga_waddr, vga_wdata);
         end else begin
            wr_t e;
            e = q.pop_front();
            chk("wr_addr", 32'(vga_waddr), 32'(e.a));
            chk("wr_data", 32'(vga_wdata), 32'(e.d));
         end
      end
   end

   task automatic drive(input logic v0, input logic [13:0] a0, input logic [7:0] d0,
                        input logic v1, input logic [13:0] a1, input logic [7:0] d1,
                        input logic cs, input logic er0, input logic er1, input string nm);
      @(negedge clk48);
      req0_valid = v0; req0_addr = a0; req0_data = d0;
      req1_valid = v1; req1_addr = a1; req1_data = d1;
      clear_start = cs;
      #1;
      chk({nm, "_rdy0"}, 32'(req0_ready), 32'(er0));
      chk({nm, "_rdy1"}, 32'(req1_ready), 32'(er1));
      if (er0)      q.push_back(wr_t'{a0, d0});
      else if (er1) q.push_back(wr_t'{a1, d1});
   endtask

`ifdef VGA_ARB_CLEAR_EN
   task automatic run_clear(input int restart_at, input logic exp_g0);
      int busy;
      drive(1, 14'h0001, 8'hAA, 1, 14'h0002, 8'hBB, 1, 0, 0, "clr_start");
      for (int i = 0; i < 16; i++) q.push_back(wr_t'{14'(i), 8'h00});
      busy = 0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk48);
         clear_start = (c == restart_at);
         #1;
         if (!clear_busy) break;
         busy++;
         chk("clr_no_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
      end
      clear_start = 1'b0;
      chk("clr_busy_cycles", 32'(busy), 32'd16);
      chk("clr_first_g0", 32'(req0_ready), 32'(exp_g0));
      chk("clr_first_g1", 32'(req1_ready), 32'(!exp_g0));
      if (exp_g0) q.push_back(wr_t'{14'h0001, 8'hAA});
      else        q.push_back(wr_t'{14'h0002, 8'hBB});
      drive(0, 14'h0, 8'h0, 0, 14'h0, 8'h0, 0, 0, 0, "clr_idle");
      chk("clr_q_empty", 32'(q.size()), 32'd0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

   initial begin
      tbl[0]  = '{1'b1, 14'h0010, 8'h41, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0};
      tbl[1]  = '{1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0};
      tbl[2]  = '{1'b0, 14'h0000, 8'h00, 1'b1, 14'h0020, 8'h7E, 1'b0, 1'b1};
      tbl[3]  = '{1'b1, 14'h0001, 8'hAA, 1'b1, 14'h0002, 8'hBB, 1'b1, 1'b0};
      tbl[4]  = '{1'b1, 14'h0001, 8'hAA, 1'b1, 14'h0002, 8'hBB, 1'b0, 1'b1};
      tbl[5]  = '{1'b1, 14'h0001, 8'hAA, 1'b1, 14'h0002, 8'hBB, 1'b1, 1'b0};
      tbl[6]  = '{1'b1, 14'h0001, 8'hAA, 1'b1, 14'h0002, 8'hBB, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 14'h0000, 8'h00, 1'b1, 14'h3FFF, 8'hFF, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 14'h3FFF, 8'h01, 1'b0, 14'h0000, 8'h00, 1'b1, 1'b0};
      tbl[9]  = '{1'b0, 14'h0000, 8'h00, 1'b0, 14'h0000, 8'h00, 1'b0, 1'b0};
      tbl[10] = '{1'b1, 14'h0100, 8'hC3, 1'b1, 14'h0200, 8'h3C, 1'b0, 1'b1};

      // Reset state, with both requesters already asking
      rst_n = 1'b0; clear_start = 1'b0;
      req0_valid = 1'b1; req0_addr = 14'h0005; req0_data = 8'h55;
      req1_valid = 1'b1; req1_addr = 14'h0006; req1_data = 8'h66;
      repeat (3) @(negedge clk48);
      #1;
      chk("rst_wr_en", 32'(vga_wr_en), 32'd0);
      chk("rst_waddr", 32'(vga_waddr), 32'd0);
      chk("rst_wdata", 32'(vga_wdata), 32'd0);
      chk("rst_busy",  32'(clear_busy), 32'd0);
      chk("rst_rdy",   {30'd0, req0_ready, req1_ready}, 32'd0);
      req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk48);
      rst_n = 1'b1;

      for (int i = 0; i < NV; i++)
         drive(tbl[i].v0, tbl[i].a0, tbl[i].d0, tbl[i].v1, tbl[i].a1, tbl[i].d1,
               1'b0, tbl[i].er0, tbl[i].er1, $sformatf("vec%0d", i));
      drive(0, 14'h0, 8'h0, 0, 14'h0, 8'h0, 0, 0, 0, "vec_idle");
      chk("vec_q_empty", 32'(q.size()), 32'd0);

`ifdef VGA_ARB_CLEAR_EN
      run_clear(-1, 1'b1);
      run_clear(5, 1'b0);

      // Reset in the middle of a clear
      drive(1, 14'h0001, 8'hAA, 1, 14'h0002, 8'hBB, 1, 0, 0, "rc_start");
      for (int i = 0; i < 16; i++) q.push_back(wr_t'{14'(i), 8'h00});
      @(negedge clk48);
      clear_start = 1'b0;
      repeat (6) @(negedge clk48);
      #1;
      chk("rc_busy_before", 32'(clear_busy), 32'd1);
      @(negedge clk48);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("rc_wr_en", 32'(vga_wr_en), 32'd0);
      chk("rc_busy",  32'(clear_busy), 32'd0);
      chk("rc_rdy",   {30'd0, req0_ready, req1_ready}, 32'd0);
`else
      // clear_start has no effect: arbitration continues
      drive(1, 14'h0001, 8'hAA, 1, 14'h0002, 8'hBB, 1, 1, 0, "nc_cs0");
      #1 chk("nc_busy0", 32'(clear_busy), 32'd0);
      drive(1, 14'h0001, 8'hAA, 1, 14'h0002, 8'hBB, 0, 0, 1, "nc_cs1");
      drive(1, 14'h0001, 8'hAA, 1, 14'h0002, 8'hBB, 1, 1, 0, "nc_cs2");
      #1 chk("nc_busy2", 32'(clear_busy), 32'd0);
      drive(1, 14'h0001, 8'hAA, 1, 14'h0002, 8'hBB, 0, 0, 1, "nc_pre_rst");
      @(negedge clk48);
      #1 chk("nc_wr_before", 32'(vga_wr_en), 32'd1);
      rst_n = 1'b0;
      #1;
      q.delete();
      chk("nr_wr_en", 32'(vga_wr_en), 32'd0);
      chk("nr_busy",  32'(clear_busy), 32'd0);
      chk("nr_rdy",   {30'd0, req0_ready, req1_ready}, 32'd0);
`endif

      // After release the pointer is back to its reset value: tie goes to req0
      @(negedge clk48);
      rst_n = 1'b1;
      #1;
      chk("post_rst_g0", 32'(req0_ready), 32'd1);
      chk("post_rst_g1", 32'(req1_ready), 32'd0);
      chk("post_rst_busy", 32'(clear_busy), 32'd0);
      q.push_back(wr_t'{14'h0001, 8'hAA});
      drive(0, 14'h0, 8'h0, 0, 14'h0, 8'h0, 0, 0, 0, "end_idle");
      chk("end_q_empty", 32'(q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
